mdom_bsum: RTL

Baseline-sum engine for one mDOM ADC channel, directly downstream of the baseline-sum configuration bundle fan-out. It consumes the unpacked controls (pause, pause_override, sum_len_sel, pause_len, dev_low, dev_high) and accumulates power-of-two windows of quiet ADC samples to produce a running 12-bit baseline. Windows are discarded and sampling is held off around pulses, signalled either by an external `pause` or by a sample straying outside a band around the current baseline. The trigger and readout logic downstream use the baseline output.

---
 rtl/mdom_bsum_if.sv | 30 +++
 rtl/mdom_bsum.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mdom_bsum_if.sv
// mdom_bsum_if: groups the sample stream, the unpacked baseline-sum controls and
// the baseline results of one mDOM ADC channel. The master drives the samples and
// controls and receives the results. The slave is the mdom_bsum engine.
interface mdom_bsum_if;
    logic [11:0] adc_data;
    logic        adc_valid;
    logic        pause;
    logic        pause_override;
    logic [2:0]  sum_len_sel;
    logic [15:0] pause_len;
    logic [11:0] dev_low;
    logic [11:0] dev_high;
    logic [22:0] bsum;
    logic [11:0] baseline;
    logic        baseline_valid;
    logic        bsum_stb;
    logic        paused;

    modport master (
        output adc_data, adc_valid, pause, pause_override,
               sum_len_sel, pause_len, dev_low, dev_high,
        input  bsum, baseline, baseline_valid, bsum_stb, paused
    );

    modport slave (
        input  adc_data, adc_valid, pause, pause_override,
               sum_len_sel, pause_len, dev_low, dev_high,
        output bsum, baseline, baseline_valid, bsum_stb, paused
    );
endinterface

// File: rtl/mdom_bsum.sv
// mdom_bsum: baseline-sum engine for one mDOM ADC channel.
// It accumulates power-of-two windows of quiet samples into a running 12-bit
// baseline. A window is thrown away, and sampling is held off, whenever a pulse
// is signalled by `pause` or by a sample leaving the band around the baseline.
// Optional feature macro: MDOM_BSUM_DEV_CHECK_EN enables excursion detection.
// Without it, only `pause` causes holdoff and dev_low/dev_high are ignored.
module mdom_bsum (
    input  logic           clk,
    input  logic           rst,
    mdom_bsum_if.slave     bus
);

    localparam logic [0:0] ST_ACCUM   = 1'b0;
    localparam logic [0:0] ST_HOLDOFF = 1'b1;

    logic [0:0]  state_r;
    logic [22:0] acc_r;
    logic [11:0] cnt_r;
    logic [2:0]  win_sel_r;
    logic [15:0] hold_cnt_r;
    logic [22:0] bsum_r;
    logic [11:0] baseline_r;
    logic        baseline_valid_r;
    logic        bsum_stb_r;
    logic        paused_r;

    logic [2:0]  win_sel_s;
    logic [11:0] win_last_s;
    logic [22:0] sum_s;
    logic [3:0]  shamt_s;
    logic [22:0] shifted_s;
    logic [11:0] base_new_s;
    logic        excursion_s;
    logic        hold_s;

    // Window geometry: the length comes from sum_len_sel at window start, else from the latched copy.
    always_comb begin
        win_sel_s = win_sel_r;
        if (cnt_r == 12'd0) begin
            win_sel_s = bus.sum_len_sel;
        end else begin
            win_sel_s = win_sel_r;
        end
        win_last_s = (12'd16 << win_sel_s) - 12'd1;
        sum_s      = acc_r + {11'd0, bus.adc_data};
        shamt_s    = {1'b0, win_sel_s} + 4'd4;
        shifted_s  = sum_s >> shamt_s;
        base_new_s = shifted_s[11:0];
    end

`ifdef MDOM_BSUM_DEV_CHECK_EN
    // Lower edge of the quiet band, clamped at 0.
    function automatic logic [11:0] low_bound(input logic [11:0] base, input logic [11:0] dev);
        logic [11:0] res;
        if (dev > base) begin
            res = 12'd0;
        end else begin
            res = base - dev;
        end
        return res;
    endfunction

    // Upper edge of the quiet band, clamped at full scale.
    function automatic logic [11:0] high_bound(input logic [11:0] base, input logic [11:0] dev);
        logic [12:0] sum;
        logic [11:0] res;
        sum = {1'b0, base} + {1'b0, dev};
        if (sum[12]) begin
            res = 12'hFFF;
        end else begin
            res = sum[11:0];
        end
        return res;
    endfunction

    logic [11:0] lo_s;
    logic [11:0] hi_s;

    // Excursion check against the registered baseline, armed once a baseline exists.
    always_comb begin
        lo_s = low_bound(baseline_r, bus.dev_low);
        hi_s = high_bound(baseline_r, bus.dev_high);
        if (baseline_valid_r && ((bus.adc_data < lo_s) || (bus.adc_data > hi_s))) begin
            excursion_s = 1'b1;
        end else begin
            excursion_s = 1'b0;
        end
    end
`else
    logic unused_dev_s;
    assign unused_dev_s = ^{bus.dev_low, bus.dev_high};

    // Excursion detection is compiled out, so only the external pause can hold off.
    always_comb begin
        excursion_s = 1'b0;
    end
`endif

    assign hold_s = bus.adc_valid & ~bus.pause_override & (bus.pause | excursion_s);

    // Window accumulation, holdoff sequencing and registered result update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r          <= ST_ACCUM;
            acc_r            <= 23'd0;
            cnt_r            <= 12'd0;
            win_sel_r        <= 3'd0;
            hold_cnt_r       <= 16'd0;
            bsum_r           <= 23'd0;
            baseline_r       <= 12'd0;
            baseline_valid_r <= 1'b0;
            bsum_stb_r       <= 1'b0;
            paused_r         <= 1'b0;
        end else begin
            bsum_stb_r <= 1'b0;
            if (bus.adc_valid) begin
                case (state_r)
                    ST_ACCUM: begin
                        if (hold_s) begin
                            // The offending sample and the partial window are dropped.
                            acc_r      <= 23'd0;
                            cnt_r      <= 12'd0;
                            hold_cnt_r <= bus.pause_len;
                            state_r    <= ST_HOLDOFF;
                            paused_r   <= 1'b1;
                        end else if (cnt_r == win_last_s) begin
                            bsum_r           <= sum_s;
                            baseline_r       <= base_new_s;
                            bsum_stb_r       <= 1'b1;
                            baseline_valid_r <= 1'b1;
                            acc_r            <= 23'd0;
                            cnt_r            <= 12'd0;
                        end else begin
                            acc_r     <= sum_s;
                            cnt_r     <= cnt_r + 12'd1;
                            win_sel_r <= win_sel_s;
                        end
                    end
                    ST_HOLDOFF: begin
                        if (hold_s) begin
                            hold_cnt_r <= bus.pause_len;
                        end else if (hold_cnt_r == 16'd0) begin
                            // The exit sample is dropped; the next one opens a new window.
                            state_r  <= ST_ACCUM;
                            paused_r <= 1'b0;
                        end else begin
                            hold_cnt_r <= hold_cnt_r - 16'd1;
                        end
                    end
                    default: begin
                        state_r  <= ST_ACCUM;
                        paused_r <= 1'b0;
                        acc_r    <= 23'd0;
                        cnt_r    <= 12'd0;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign bus.bsum           = bsum_r;
    assign bus.baseline       = baseline_r;
    assign bus.baseline_valid = baseline_valid_r;
    assign bus.bsum_stb       = bsum_stb_r;
    assign bus.paused         = paused_r;

endmodule
